pipe_hazard_ctrl: RTL and testbench

//  Hazard and stall controller for the 5-stage pipeline; drives the stall/flush controls of the F/D, D/E and E/M registers.

---
 rtl/pipe_hazard_ctrl_if.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: pipeline-stage register ids and controls in,
// stall/flush/forward controls and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic [4:0]           RA1_D, RA2_D, RA1_E, RA2_E;
  logic [4:0]           WRITE_REG_E, WRITE_REG_M, WRITE_REG_W;
  logic                 REG_WRITE_E, MEM_TO_REG_E, REG_WRITE_M, REG_WRITE_W;
  logic                 BRANCH_TAKEN_E, MEM_REQ_M, MEM_READY, CNT_CLR;
  logic                 STALL_F, STALL_D, STALL_E, STALL_M;
  logic                 FLUSH_D, FLUSH_E;
  logic [1:0]           FORWARD_A_E, FORWARD_B_E;
  logic [CNT_WIDTH-1:0] STALL_CNT, FLUSH_CNT;
  logic                 HALT_ERR;

  modport master (
    output RA1_D, RA2_D, RA1_E, RA2_E, WRITE_REG_E, WRITE_REG_M, WRITE_REG_W,
           REG_WRITE_E, MEM_TO_REG_E, REG_WRITE_M, REG_WRITE_W,
           BRANCH_TAKEN_E, MEM_REQ_M, MEM_READY, CNT_CLR,
    input  STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E,
           FORWARD_A_E, FORWARD_B_E, STALL_CNT, FLUSH_CNT, HALT_ERR
  );

  modport slave (
    input  RA1_D, RA2_D, RA1_E, RA2_E, WRITE_REG_E, WRITE_REG_M, WRITE_REG_W,
           REG_WRITE_E, MEM_TO_REG_E, REG_WRITE_M, REG_WRITE_W,
           BRANCH_TAKEN_E, MEM_REQ_M, MEM_READY, CNT_CLR,
    output STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E,
           FORWARD_A_E, FORWARD_B_E, STALL_CNT, FLUSH_CNT, HALT_ERR
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use / branch / memory-wait stalls
// and flushes, E-stage forwarding selects, saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              CLK,
  input  logic              CLR_N,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t               state, state_nxt;
  logic [WW-1:0]        wait_cnt, wait_nxt;
  logic                 halt_err, halt_nxt;
  logic                 lu_prev, lu_fire;
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;
  logic                 memwait, lu_hit, hz_flush, timeout_hit;
  logic                 stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;

  assign memwait     = bus.MEM_REQ_M & ~bus.MEM_READY;
  assign lu_hit      = bus.MEM_TO_REG_E & bus.REG_WRITE_E & (bus.WRITE_REG_E != 5'd0) &
                       ((bus.WRITE_REG_E == bus.RA1_D) | (bus.WRITE_REG_E == bus.RA2_D));
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WW'(TIMEOUT - 1));

  function automatic logic [1:0] fwd_sel(input logic [4:0] ra);
    if (bus.REG_WRITE_M && bus.WRITE_REG_M != 5'd0 && bus.WRITE_REG_M == ra)
      return 2'b10;
    else if (bus.REG_WRITE_W && bus.WRITE_REG_W != 5'd0 && bus.WRITE_REG_W == ra)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    halt_nxt  = halt_err;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    hz_flush  = 1'b0;
    lu_fire   = 1'b0;
    case (state)
      HALT: begin
        {stall_f, stall_d, stall_e, stall_m} = 4'hF;
      end
      default: begin
        if (memwait) begin
          {stall_f, stall_d, stall_e, stall_m} = 4'hF;
          if (timeout_hit) begin
            state_nxt = HALT;
            halt_nxt  = 1'b1;
          end else begin
            state_nxt = MEM_WAIT;
            wait_nxt  = wait_cnt + WW'(1);
          end
        end else begin
          state_nxt = RUN;
          wait_nxt  = '0;
          if (bus.BRANCH_TAKEN_E) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            hz_flush = 1'b1;
          end else if (lu_hit && !lu_prev) begin
            // the bubble retires the load from E; suppress a repeat on held inputs
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            flush_e  = 1'b1;
            hz_flush = 1'b1;
            lu_fire  = 1'b1;
          end
        end
      end
    endcase
  end

  // Reset must bubble the pipeline registers immediately, not a cycle later
  always_comb begin
    if (!CLR_N) begin
      bus.STALL_F     = 1'b0;
      bus.STALL_D     = 1'b0;
      bus.STALL_E     = 1'b0;
      bus.STALL_M     = 1'b0;
      bus.FLUSH_D     = 1'b1;
      bus.FLUSH_E     = 1'b1;
      bus.FORWARD_A_E = 2'b00;
      bus.FORWARD_B_E = 2'b00;
    end else begin
      bus.STALL_F     = stall_f;
      bus.STALL_D     = stall_d;
      bus.STALL_E     = stall_e;
      bus.STALL_M     = stall_m;
      bus.FLUSH_D     = flush_d;
      bus.FLUSH_E     = flush_e;
      bus.FORWARD_A_E = fwd_sel(bus.RA1_E);
      bus.FORWARD_B_E = fwd_sel(bus.RA2_E);
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state     <= RUN;
      wait_cnt  <= '0;
      halt_err  <= 1'b0;
      lu_prev   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      halt_err <= halt_nxt;
      lu_prev  <= lu_fire;
      if (bus.CNT_CLR) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (stall_f && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        if (hz_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign bus.STALL_CNT = stall_cnt;
  assign bus.FLUSH_CNT = flush_cnt;
  assign bus.HALT_ERR  = halt_err;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, forwarding, memory wait,
// branch under wait, timeout/HALT, counter saturation and clear.
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;
  localparam int TO = 4;

  logic CLK = 1'b0;
  logic CLR_N = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  pipe_hazard_ctrl #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.RA1_D = 0; bus.RA2_D = 0; bus.RA1_E = 0; bus.RA2_E = 0;
    bus.WRITE_REG_E = 0; bus.WRITE_REG_M = 0; bus.WRITE_REG_W = 0;
    bus.REG_WRITE_E = 0; bus.MEM_TO_REG_E = 0; bus.REG_WRITE_M = 0; bus.REG_WRITE_W = 0;
    bus.BRANCH_TAKEN_E = 0; bus.MEM_REQ_M = 0; bus.MEM_READY = 0; bus.CNT_CLR = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] stalls();
    return {bus.STALL_F, bus.STALL_D, bus.STALL_E, bus.STALL_M};
  endfunction

  function automatic logic [1:0] flushes();
    return {bus.FLUSH_D, bus.FLUSH_E};
  endfunction

  initial begin
    // reset state, forwarding suppressed while in reset
    idle();
    bus.REG_WRITE_M = 1; bus.WRITE_REG_M = 3; bus.RA1_E = 3;
    #3;
    chk("rst_flush", flushes(), 2'b11);
    chk("rst_stall", stalls(), 4'h0);
    chk("rst_fwd_a", bus.FORWARD_A_E, 2'b00);
    chk("rst_stall_cnt", bus.STALL_CNT, 0);
    chk("rst_flush_cnt", bus.FLUSH_CNT, 0);
    chk("rst_halt", bus.HALT_ERR, 0);
    #9 CLR_N = 1'b1;
    idle();
    tick();
    chk("run_idle", {stalls(), flushes()}, 6'h00);

    // 1: load-use on $5
    bus.MEM_TO_REG_E = 1; bus.REG_WRITE_E = 1; bus.WRITE_REG_E = 5; bus.RA1_D = 5;
    #1;
    chk("lu_stall", stalls(), 4'hC);
    chk("lu_flush", flushes(), 2'b01);
    tick();
    chk("lu_single", {stalls(), flushes()}, 6'h00);
    chk("lu_stall_cnt", bus.STALL_CNT, 1);
    chk("lu_flush_cnt", bus.FLUSH_CNT, 1);
    idle();
    tick();
    bus.MEM_TO_REG_E = 1; bus.REG_WRITE_E = 1; bus.WRITE_REG_E = 9; bus.RA2_D = 9;
    #1;
    chk("lu_rb_stall", stalls(), 4'hC);
    idle();
    tick();

    // 2: lw $0 never stalls; forwarding priority
    bus.MEM_TO_REG_E = 1; bus.REG_WRITE_E = 1; bus.WRITE_REG_E = 0; bus.RA1_D = 0;
    bus.REG_WRITE_M = 1; bus.WRITE_REG_M = 3; bus.RA1_E = 3;
    bus.REG_WRITE_W = 1; bus.WRITE_REG_W = 3; bus.RA2_E = 7;
    #1;
    chk("lw0_nostall", {stalls(), flushes()}, 6'h00);
    chk("fwd_a_m", bus.FORWARD_A_E, 2'b10);
    chk("fwd_b_none", bus.FORWARD_B_E, 2'b00);
    bus.RA2_E = 3; bus.REG_WRITE_M = 0;
    #1;
    chk("fwd_a_w", bus.FORWARD_A_E, 2'b01);
    chk("fwd_b_w", bus.FORWARD_B_E, 2'b01);
    bus.REG_WRITE_M = 1; bus.WRITE_REG_M = 0; bus.RA1_E = 0; bus.WRITE_REG_W = 0;
    #1;
    chk("fwd_a_r0", bus.FORWARD_A_E, 2'b00);
    idle();
    bus.CNT_CLR = 1;
    tick();
    bus.CNT_CLR = 0;
    chk("clr_stall_cnt", bus.STALL_CNT, 0);

    // 3: three memory-wait cycles
    bus.MEM_REQ_M = 1; bus.MEM_READY = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_stall%0d", i), {stalls(), flushes()}, 6'h3C);
      tick();
    end
    bus.MEM_READY = 1;
    #1;
    chk("mw_release", {stalls(), flushes()}, 6'h00);
    chk("mw_stall_cnt", bus.STALL_CNT, 3);
    idle();
    bus.CNT_CLR = 1;
    tick();
    bus.CNT_CLR = 0;

    // 4: branch held off by memwait, flushes on release
    bus.BRANCH_TAKEN_E = 1; bus.MEM_REQ_M = 1; bus.MEM_READY = 0;
    bus.MEM_TO_REG_E = 1; bus.REG_WRITE_E = 1; bus.WRITE_REG_E = 4; bus.RA1_D = 4;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("br_mw%0d", i), {stalls(), flushes()}, 6'h3C);
      tick();
    end
    bus.MEM_READY = 1;
    #1;
    chk("br_release", {stalls(), flushes()}, 6'h03);
    tick();
    chk("br_flush_cnt", bus.FLUSH_CNT, 1);
    chk("br_stall_cnt", bus.STALL_CNT, 2);
    idle();
    tick();

    // reset mid-wait drops the wait count
    bus.MEM_REQ_M = 1;
    tick();
    tick();
    CLR_N = 1'b0;
    #2;
    chk("mid_rst_out", {stalls(), flushes()}, 6'h03);
    #2;
    idle();
    CLR_N = 1'b1;
    tick();
    bus.MEM_REQ_M = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_rst_nohalt", bus.HALT_ERR, 0);
    bus.MEM_READY = 1;
    #1;
    chk("mid_rst_release", stalls(), 4'h0);
    idle();
    tick();

    // 5/6: timeout to HALT, clear-wins, saturation
    bus.MEM_REQ_M = 1; bus.CNT_CLR = 1;
    tick();
    chk("clr_wins", bus.STALL_CNT, 0);
    bus.CNT_CLR = 0;
    tick();
    tick();
    chk("to_not_yet", bus.HALT_ERR, 0);
    tick();
    chk("to_halt", bus.HALT_ERR, 1);
    chk("to_stall_cnt", bus.STALL_CNT, 3);
    bus.MEM_READY = 1; bus.BRANCH_TAKEN_E = 1;
    #1;
    chk("halt_out", {stalls(), flushes()}, 6'h3C);
    for (int i = 0; i < 12; i++) tick();
    chk("sat_reach", bus.STALL_CNT, 15);
    tick();
    tick();
    chk("sat_hold", bus.STALL_CNT, 15);
    chk("halt_sticky", bus.HALT_ERR, 1);
    bus.CNT_CLR = 1;
    tick();
    bus.CNT_CLR = 0;
    chk("halt_clr", bus.STALL_CNT, 0);
    CLR_N = 1'b0;
    #2;
    chk("halt_rst_err", bus.HALT_ERR, 0);
    #2;
    idle();
    CLR_N = 1'b1;
    #1;
    chk("post_rst_out", {stalls(), flushes()}, 6'h00);
    tick();
    chk("post_rst_run", {stalls(), flushes()}, 6'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
